// File: rtl/cc_operand_loader_if.sv
// Operand bus between the upstream feeder and the OR-stage consumer.
// slave = loader side, master = driver/consumer side.
interface cc_operand_loader_if #(
  parameter int NUMBER_DATAWIDTH  = 8,
  parameter int NUMBER_COUNTWIDTH = 8
);
  logic [NUMBER_DATAWIDTH-1:0]  CC_OPLOADER_data_In;
  logic                         CC_OPLOADER_valid_In;
  logic                         CC_OPLOADER_ready_Out;
  logic                         CC_OPLOADER_clear_In;
  logic                         CC_OPLOADER_ack_In;
  logic [NUMBER_DATAWIDTH-1:0]  CC_OPLOADER_data0_Out;
  logic [NUMBER_DATAWIDTH-1:0]  CC_OPLOADER_data1_Out;
  logic                         CC_OPLOADER_opvalid_Out;
  logic [NUMBER_COUNTWIDTH-1:0] CC_OPLOADER_count_Out;

  modport slave (
    input  CC_OPLOADER_data_In, CC_OPLOADER_valid_In, CC_OPLOADER_clear_In, CC_OPLOADER_ack_In,
    output CC_OPLOADER_ready_Out, CC_OPLOADER_data0_Out, CC_OPLOADER_data1_Out,
           CC_OPLOADER_opvalid_Out, CC_OPLOADER_count_Out
  );

  modport master (
    output CC_OPLOADER_data_In, CC_OPLOADER_valid_In, CC_OPLOADER_clear_In, CC_OPLOADER_ack_In,
    input  CC_OPLOADER_ready_Out, CC_OPLOADER_data0_Out, CC_OPLOADER_data1_Out,
           CC_OPLOADER_opvalid_Out, CC_OPLOADER_count_Out
  );
endinterface

// File: rtl/cc_operand_loader.sv
// Two-beat operand loader: captures operand 0 then operand 1 off a shared bus
// and holds the pair until the consumer acks; counts consumed pairs.
module cc_operand_loader #(
  parameter int NUMBER_DATAWIDTH  = 8,
  parameter int NUMBER_COUNTWIDTH = 8
) (
  input  logic                CC_OPLOADER_CLOCK_50,
  input  logic                CC_OPLOADER_RESET_InLow,
  cc_operand_loader_if.slave  bus
);
  typedef enum logic [1:0] {LOAD_A, LOAD_B, HOLD} state_t;

  state_t                       state, state_nxt;
  logic [NUMBER_DATAWIDTH-1:0]  data0, data1;
  logic [NUMBER_COUNTWIDTH-1:0] count;
  logic                         xfer, ld0, ld1, cnt_inc, clr;

  // ready only sees reset combinationally; everything else is a state decode
  assign bus.CC_OPLOADER_ready_Out   = CC_OPLOADER_RESET_InLow && (state != HOLD);
  assign bus.CC_OPLOADER_opvalid_Out = (state == HOLD);
  assign bus.CC_OPLOADER_data0_Out   = data0;
  assign bus.CC_OPLOADER_data1_Out   = data1;
  assign bus.CC_OPLOADER_count_Out   = count;

  assign xfer = bus.CC_OPLOADER_valid_In && (state != HOLD);

  always_comb begin
    state_nxt = state;
    ld0       = 1'b0;
    ld1       = 1'b0;
    cnt_inc   = 1'b0;
    clr       = 1'b0;
    if (bus.CC_OPLOADER_clear_In) begin
      state_nxt = LOAD_A;
      clr       = 1'b1;
    end else begin
      case (state)
        LOAD_A: if (xfer) begin
          ld0       = 1'b1;
          state_nxt = LOAD_B;
        end
        LOAD_B: if (xfer) begin
          ld1       = 1'b1;
          state_nxt = HOLD;
        end
        HOLD: if (bus.CC_OPLOADER_ack_In) begin
          cnt_inc   = 1'b1;
          state_nxt = LOAD_A;
        end
        default: state_nxt = LOAD_A;
      endcase
    end
  end

  always_ff @(posedge CC_OPLOADER_CLOCK_50) begin
    if (!CC_OPLOADER_RESET_InLow) begin
      state <= LOAD_A;
      data0 <= '0;
      data1 <= '0;
      count <= '0;
    end else begin
      state <= state_nxt;
      if (clr) begin
        data0 <= '0;
        data1 <= '0;
      end else begin
        if (ld0) data0 <= bus.CC_OPLOADER_data_In;
        if (ld1) data1 <= bus.CC_OPLOADER_data_In;
      end
      if (cnt_inc) count <= count + 1'b1;
    end
  end
endmodule

// File: tb/tb_cc_operand_loader.sv
// Directed scenarios plus random traffic against a beat-counting reference model.
module tb_cc_operand_loader;
  localparam int DW = 8;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  // reference model: number of operands currently held (0,1,2) plus values
  int          m_n;
  logic [DW-1:0] m_d0, m_d1;
  int          m_cnt;

  cc_operand_loader_if #(.NUMBER_DATAWIDTH(DW), .NUMBER_COUNTWIDTH(CW)) bus ();

  cc_operand_loader #(.NUMBER_DATAWIDTH(DW), .NUMBER_COUNTWIDTH(CW)) dut (
    .CC_OPLOADER_CLOCK_50   (clk),
    .CC_OPLOADER_RESET_InLow(rst_n),
    .bus                    (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // one clock: drive at negedge, check ready pre-edge, update model, check outputs post-edge
  task automatic step(input logic rst, input logic v, input logic [DW-1:0] d,
                      input logic clr, input logic ack);
    rst_n = rst;
    bus.CC_OPLOADER_valid_In = v;
    bus.CC_OPLOADER_data_In  = d;
    bus.CC_OPLOADER_clear_In = clr;
    bus.CC_OPLOADER_ack_In   = ack;
    #1;
    chk("ready", {31'd0, bus.CC_OPLOADER_ready_Out}, {31'd0, (rst && m_n < 2)});
    @(posedge clk);
    if (!rst) begin
      m_n = 0; m_d0 = '0; m_d1 = '0; m_cnt = 0;
    end else if (clr) begin
      m_n = 0; m_d0 = '0; m_d1 = '0;
    end else if (m_n == 2) begin
      if (ack) begin
        m_n = 0;
        m_cnt = (m_cnt + 1) % (1 << CW);
      end
    end else if (v) begin
      if (m_n == 0) m_d0 = d; else m_d1 = d;
      m_n++;
    end
    #1;
    chk("data0",   {24'd0, bus.CC_OPLOADER_data0_Out}, {24'd0, m_d0});
    chk("data1",   {24'd0, bus.CC_OPLOADER_data1_Out}, {24'd0, m_d1});
    chk("opvalid", {31'd0, bus.CC_OPLOADER_opvalid_Out}, {31'd0, (m_n == 2)});
    chk("count",   {24'd0, bus.CC_OPLOADER_count_Out}, m_cnt);
    @(negedge clk);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    m_n = 0; m_d0 = '0; m_d1 = '0; m_cnt = 0;
    do_reset();
    do_reset();
    chk("rst_d0", {24'd0, bus.CC_OPLOADER_data0_Out}, 32'h0);
    chk("rst_cnt", {24'd0, bus.CC_OPLOADER_count_Out}, 32'h0);

    // basic pair
    step(1, 1, 8'h0F, 0, 0);
    step(1, 1, 8'hA0, 0, 0);
    chk("pair_d0", {24'd0, bus.CC_OPLOADER_data0_Out}, 32'h0F);
    chk("pair_d1", {24'd0, bus.CC_OPLOADER_data1_Out}, 32'hA0);
    chk("pair_ov", {31'd0, bus.CC_OPLOADER_opvalid_Out}, 32'h1);
    step(1, 0, 8'h00, 0, 1);
    chk("pair_cnt", {24'd0, bus.CC_OPLOADER_count_Out}, 32'h1);

    // backpressure: valid ignored in HOLD, including on the ack edge
    do_reset();
    step(1, 1, 8'h12, 0, 0);
    step(1, 1, 8'h34, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 1, 8'hFF, 0, 0);
    chk("bp_d0", {24'd0, bus.CC_OPLOADER_data0_Out}, 32'h12);
    chk("bp_d1", {24'd0, bus.CC_OPLOADER_data1_Out}, 32'h34);
    step(1, 1, 8'hFF, 0, 1);
    chk("bp_cnt", {24'd0, bus.CC_OPLOADER_count_Out}, 32'h1);
    chk("bp_nocap", {24'd0, bus.CC_OPLOADER_data0_Out}, 32'h12);
    step(1, 1, 8'h77, 0, 0);
    chk("bp_next", {24'd0, bus.CC_OPLOADER_data0_Out}, 32'h77);

    // clear mid-pair
    do_reset();
    step(1, 1, 8'h55, 0, 0);
    step(1, 1, 8'h33, 1, 0);
    chk("clr_d0", {24'd0, bus.CC_OPLOADER_data0_Out}, 32'h0);
    step(1, 1, 8'h33, 0, 0);
    chk("clr_next", {24'd0, bus.CC_OPLOADER_data0_Out}, 32'h33);

    // count wrap
    do_reset();
    for (int i = 0; i < 256; i++) begin
      step(1, 1, 8'($urandom), 0, 0);
      step(1, 1, 8'($urandom), 0, 0);
      step(1, 0, 8'h00, 0, 1);
    end
    chk("wrap_cnt", {24'd0, bus.CC_OPLOADER_count_Out}, 32'h0);
    step(1, 1, 8'h01, 0, 0);
    step(1, 1, 8'h02, 0, 0);
    step(1, 0, 8'h00, 0, 1);
    step(1, 0, 8'h00, 0, 1);
    chk("ackA_cnt", {24'd0, bus.CC_OPLOADER_count_Out}, 32'h1);

    // synchronous reset while holding a pair
    step(1, 1, 8'hDE, 0, 0);
    step(1, 1, 8'hAD, 0, 0);
    do_reset();
    chk("rh_d1", {24'd0, bus.CC_OPLOADER_data1_Out}, 32'h0);
    chk("rh_cnt", {24'd0, bus.CC_OPLOADER_count_Out}, 32'h0);
    step(1, 0, 8'h00, 0, 0);

    // gaps between beats
    step(1, 1, 8'hC3, 0, 0);
    step(1, 0, 8'h5A, 0, 0);
    step(1, 0, 8'hA5, 0, 0);
    chk("gap_ov0", {31'd0, bus.CC_OPLOADER_opvalid_Out}, 32'h0);
    step(1, 1, 8'h3C, 0, 0);
    chk("gap_ov1", {31'd0, bus.CC_OPLOADER_opvalid_Out}, 32'h1);
    chk("gap_d0", {24'd0, bus.CC_OPLOADER_data0_Out}, 32'hC3);
    chk("gap_d1", {24'd0, bus.CC_OPLOADER_data1_Out}, 32'h3C);
    step(1, 0, 8'h00, 0, 1);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(99) >= 2,
           $urandom_range(99) < 60,
           8'($urandom),
           $urandom_range(99) < 5,
           $urandom_range(99) < 40);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/cc_operand_loader.md
Name: cc_operand_loader

Overview:
- Upstream feeder for the combinational bitwise-OR stage.
- Takes operands from a single shared NUMBER_DATAWIDTH-bit bus with a valid/ready handshake.
- Captures first beat as operand 0 and second beat as operand 1.
- Presents both as a stable registered pair with a valid flag until the consumer acknowledges; keeps a wrapping count of consumed pairs.

Parameters:
- NUMBER_DATAWIDTH, 8, width of bus and of each operand.
- NUMBER_COUNTWIDTH, 8, width of consumed-pair counter.

Ports:
- CC_OPLOADER_CLOCK_50  in  1  single clock, all state on rising edge.
- CC_OPLOADER_RESET_InLow  in  1  synchronous active-low reset.
- CC_OPLOADER_data_In  in  NUMBER_DATAWIDTH  shared operand bus.
- CC_OPLOADER_valid_In  in  1  bus beat valid.
- CC_OPLOADER_ready_Out  out  1  loader can accept a beat.
- CC_OPLOADER_clear_In  in  1  synchronous abort of current pair.
- CC_OPLOADER_ack_In  in  1  consumer has used the presented pair.
- CC_OPLOADER_data0_Out  out  NUMBER_DATAWIDTH  operand 0, drives OR data0.
- CC_OPLOADER_data1_Out  out  NUMBER_DATAWIDTH  operand 1, drives OR data1.
- CC_OPLOADER_opvalid_Out  out  1  data0/data1 form a complete valid pair.
- CC_OPLOADER_count_Out  out  NUMBER_COUNTWIDTH  consumed pairs, wraps.

Behaviour:
- Reset and clear:
  - Reset is sampled only on a rising edge with RESET_InLow=0.
  - Reset result: state LOAD_A, data0=0, data1=0, opvalid=0, count=0.
  - ready_Out is forced 0 combinationally while RESET_InLow=0.
- Beat transfer occurs on an edge where valid_In=1 and ready_Out=1.
- States (encoding free):
  - LOAD_A: ready=1, opvalid=0. On transfer, data0<=data_In and go to LOAD_B.
  - LOAD_B: ready=1, opvalid=0. On transfer, data1<=data_In and go to HOLD. data0 holds.
  - HOLD: ready=0, opvalid=1. data0/data1 are frozen.
    - On ack_In=1: go to LOAD_A and count<=count+1 (modulo 2^NUMBER_COUNTWIDTH, all-ones wraps to 0).
    - Otherwise stay in HOLD indefinitely.
- Output timing:
  - ready and opvalid are pure decodes of the registered state (no input-to-output combinational path except reset on ready).
  - data0/data1 are registers.
- Latency:
  - opvalid rises the cycle after the edge capturing the second beat.
  - Minimum 3 cycles per pair (A, B, HOLD with immediate ack).
  - No bypass: in HOLD, valid_In is ignored even when ack_In=1 on the same edge.
- Priority per edge, highest first:
  1. reset
  2. clear_In=1: go to LOAD_A, data0<=0, data1<=0, count unchanged, any same-cycle beat or ack is discarded.
  3. normal handshake.
- Clear in LOAD_B discards the captured operand 0.
- ack_In outside HOLD is ignored; no count change.
- valid_In while ready=0 is ignored; the upstream must hold the beat.
- data0 is not overwritten in LOAD_B or HOLD. data1 is not overwritten in LOAD_A or HOLD, so the previous data1 stays visible with opvalid=0.
- Reset mid-pair (in LOAD_B or HOLD) returns to LOAD_A with all registers cleared; count is also cleared.

Test Plan:
- Basic pair: after reset, drive beats 0x0F then 0xA0 on consecutive cycles with valid=1, then ack=1 on the first cycle opvalid=1 -> ready high in LOAD_A/LOAD_B. Next cycle: data0=0x0F, data1=0xA0, opvalid=1, ready=0. After ack: opvalid=0, ready=1, count=1.
- Backpressure: hold in HOLD with ack=0 for 10 cycles while valid=1 with data 0xFF -> data0/data1 unchanged, ready=0. Then ack=1 and valid=1 on the same edge -> no capture, count=1, next beat lands in data0.
- Clear mid-pair: load 0x55 into data0, then clear=1 with valid=1 and data 0x33 on the same edge -> state LOAD_A, data0=0, data1=0, opvalid=0, count unchanged. The next beat 0x33 lands in data0.
- Count wrap: complete 256 pairs with NUMBER_COUNTWIDTH=8 -> count=0 after the 256th ack. Also issue ack while in LOAD_A -> count unchanged.
- Synchronous reset in HOLD: assert RESET_InLow=0 for one edge while opvalid=1 -> ready=0 during reset. After the edge: data0=data1=0, opvalid=0, count=0. After reset release: ready=1.
- Gaps: valid toggles 1,0,0,1 with data 0xC3, xx, xx, 0x3C -> data0=0xC3, data1=0x3C. opvalid asserts exactly one cycle after the 0x3C edge.
